// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor: 2-bit counter
// encodings, the init/run state enum, BTB tag width and counter update.
package bp_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'd0,
        CTR_WNT = 2'd1,
        CTR_WT  = 2'd2,
        CTR_ST  = 2'd3
    } ctr_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Tag covers the PC above the BTB index and the 2-bit word offset.
    function automatic int btb_tag_bits(input int dbits, input int idx_bits);
        return dbits - idx_bits - 2;
    endfunction

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == CTR_ST) ? ctr : ctr + 2'd1;
        end else begin
            res = (ctr == CTR_SNT) ? ctr : ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_gshare_param_if.sv
// Predictor port bundle: fetch-side lookup, resolve-side update, status.
// master = pipeline driving lookups/updates, slave = predictor.
interface bp_gshare_param_if #(
    parameter int DBITS     = 32,
    parameter int HIST_BITS = 8
);
    logic                 pred_valid;
    logic [DBITS-1:0]     pred_pc;
    logic                 pred_taken;
    logic                 pred_btb_hit;
    logic [DBITS-1:0]     pred_target;
    logic [HIST_BITS-1:0] pred_pht_idx;
    logic [HIST_BITS-1:0] pred_ckpt;

    logic                 upd_valid;
    logic [DBITS-1:0]     upd_pc;
    logic [DBITS-1:0]     upd_target;
    logic                 upd_taken;
    logic                 upd_mispred;
    logic [HIST_BITS-1:0] upd_pht_idx;
    logic [HIST_BITS-1:0] upd_ckpt;

    logic                 ready;
    logic [31:0]          perf_mispred_cnt;

    modport master (
        output pred_valid, pred_pc,
        output upd_valid, upd_pc, upd_target, upd_taken, upd_mispred, upd_pht_idx, upd_ckpt,
        input  pred_taken, pred_btb_hit, pred_target, pred_pht_idx, pred_ckpt,
        input  ready, perf_mispred_cnt
    );

    modport slave (
        input  pred_valid, pred_pc,
        input  upd_valid, upd_pc, upd_target, upd_taken, upd_mispred, upd_pht_idx, upd_ckpt,
        output pred_taken, pred_btb_hit, pred_target, pred_pht_idx, pred_ckpt,
        output ready, perf_mispred_cnt
    );
endinterface

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: valid/tag/target arrays, combinational
// lookup compare and one write port. Valid bits are cleared by the init sweep.
module bp_btb
    import bp_pkg::*;
#(
    parameter int DBITS    = 32,
    parameter int IDX_BITS = 4
) (
    input  logic                clk,
    input  logic                clr_en,
    input  logic [IDX_BITS-1:0] clr_idx,
    input  logic [DBITS-1:0]    lk_pc,
    output logic                lk_hit,
    output logic [DBITS-1:0]    lk_target,
    input  logic                wr_en,
    input  logic [DBITS-1:0]    wr_pc,
    input  logic [DBITS-1:0]    wr_target
);
    localparam int TAG_BITS = btb_tag_bits(DBITS, IDX_BITS);
    localparam int N        = 1 << IDX_BITS;

    logic                valid  [N];
    logic [TAG_BITS-1:0] tag    [N];
    logic [DBITS-1:0]    target [N];

    logic [IDX_BITS-1:0] lk_idx, wr_idx;
    logic [TAG_BITS-1:0] lk_tag, wr_tag;
    logic                unused_lsb;

    assign lk_idx     = lk_pc[IDX_BITS+1:2];
    assign lk_tag     = lk_pc[DBITS-1:IDX_BITS+2];
    assign wr_idx     = wr_pc[IDX_BITS+1:2];
    assign wr_tag     = wr_pc[DBITS-1:IDX_BITS+2];
    assign unused_lsb = ^{lk_pc[1:0], wr_pc[1:0]};

    assign lk_hit    = valid[lk_idx] && (tag[lk_idx] == lk_tag);
    assign lk_target = target[lk_idx];

    // Table write: sweep clear has priority; otherwise install a taken branch.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            valid[clr_idx] <= 1'b0;
        end else if (wr_en) begin
            valid[wr_idx]  <= 1'b1;
            tag[wr_idx]    <= wr_tag;
            target[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/bp_gshare_param.sv
// Gshare direction predictor with BTB and mispredict counter.
// Optional macro BP_SPEC_HIST_EN: history shifts speculatively on lookups and
// is restored from the returned checkpoint on a mispredict. Without it the
// history shifts only on resolved updates.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_INIT | sweeping PHT/BTB one index per cycle; lookups and updates off
// ST_RUN  | tables valid, ready=1, lookups and updates active
module bp_gshare_param
    import bp_pkg::*;
#(
    parameter int DBITS        = 32,
    parameter int HIST_BITS    = 8,
    parameter int BTB_IDX_BITS = 4,   // must not exceed HIST_BITS
    parameter int CTR_INIT     = 2
) (
    input  logic            clk,
    input  logic            reset,
    bp_gshare_param_if.slave bus
);
    localparam int PHT_N = 1 << HIST_BITS;

    state_e               state, state_nxt;
    logic                 run;
    logic [HIST_BITS-1:0] sweep_idx;
    logic [HIST_BITS-1:0] bhr, bhr_nxt;
    logic [HIST_BITS-1:0] pht_idx;
    logic [1:0]           pht [PHT_N];
    logic [1:0]           ctr_rd;
    logic [31:0]          perf_cnt;
    logic                 btb_hit;
    logic                 btb_wr;

    assign run     = (state == ST_RUN);
    assign pht_idx = bhr ^ bus.pred_pc[HIST_BITS+1:2];
    assign ctr_rd  = pht[pht_idx];
    assign btb_wr  = run & bus.upd_valid & bus.upd_taken;

    assign bus.pred_taken       = run & ctr_rd[1];
    assign bus.pred_btb_hit     = run & btb_hit;
    assign bus.pred_pht_idx     = pht_idx;
    assign bus.pred_ckpt        = bhr;
    assign bus.ready            = run;
    assign bus.perf_mispred_cnt = perf_cnt;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_INIT;
        else        state <= state_nxt;
    end

    // Next state: leave INIT once the last index has been written.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (&sweep_idx) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    // Sweep index advances every INIT cycle; wraps to 0 as RUN is entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   sweep_idx <= '0;
        else if (!run) sweep_idx <= sweep_idx + 1'b1;
    end

    // PHT write port: init sweep, or saturating counter update in RUN.
    always_ff @(posedge clk) begin
        if (!run) begin
            pht[sweep_idx] <= 2'(CTR_INIT);
        end else if (bus.upd_valid) begin
            pht[bus.upd_pht_idx] <= ctr_next(pht[bus.upd_pht_idx], bus.upd_taken);
        end
    end

`ifdef BP_SPEC_HIST_EN
    // Speculative history: recovery from checkpoint wins over a lookup shift.
    always_comb begin
        bhr_nxt = bhr;
        if (run) begin
            if (bus.upd_valid && bus.upd_mispred)
                bhr_nxt = {bus.upd_ckpt[HIST_BITS-2:0], bus.upd_taken};
            else if (bus.pred_valid)
                bhr_nxt = {bhr[HIST_BITS-2:0], bus.pred_taken};
        end
    end
`else
    logic unused_spec;
    assign unused_spec = ^{bus.pred_valid, bus.upd_ckpt};

    // Non-speculative history: shift in the resolved direction.
    always_comb begin
        bhr_nxt = bhr;
        if (run && bus.upd_valid)
            bhr_nxt = {bhr[HIST_BITS-2:0], bus.upd_taken};
    end
`endif

    // History register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) bhr <= '0;
        else        bhr <= bhr_nxt;
    end

    // Saturating mispredict counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            perf_cnt <= '0;
        else if (run && bus.upd_valid && bus.upd_mispred && (perf_cnt != 32'hFFFF_FFFF))
            perf_cnt <= perf_cnt + 32'd1;
    end

    bp_btb #(
        .DBITS    (DBITS),
        .IDX_BITS (BTB_IDX_BITS)
    ) u_btb (
        .clk       (clk),
        .clr_en    (!run),
        .clr_idx   (sweep_idx[BTB_IDX_BITS-1:0]),
        .lk_pc     (bus.pred_pc),
        .lk_hit    (btb_hit),
        .lk_target (bus.pred_target),
        .wr_en     (btb_wr),
        .wr_pc     (bus.upd_pc),
        .wr_target (bus.upd_target)
    );

endmodule

// File: tb/tb_bp_gshare_param.sv
// Directed self-checking bench for bp_gshare_param (default parameters).
module tb_bp_gshare_param;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [7:0]  bhr_m;
    logic [31:0] perf_m;

    bp_gshare_param_if #(.DBITS(32), .HIST_BITS(8)) bus ();

    bp_gshare_param #(
        .DBITS        (32),
        .HIST_BITS    (8),
        .BTB_IDX_BITS (4),
        .CTR_INIT     (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic        hit;
        logic [7:0]  idx;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pc_for_idx(input logic [7:0] idx);
        return {22'd0, bhr_m ^ idx, 2'b00};
    endfunction

    function automatic logic [7:0] idx_of(input logic [31:0] pc);
        return bhr_m ^ pc[9:2];
    endfunction

    task automatic upd_drive(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                             input logic mis, input logic [7:0] idx, input logic [7:0] ckpt);
        bus.upd_valid   = 1'b1;
        bus.upd_pc      = pc;
        bus.upd_target  = tgt;
        bus.upd_taken   = taken;
        bus.upd_mispred = mis;
        bus.upd_pht_idx = idx;
        bus.upd_ckpt    = ckpt;
    endtask

    task automatic upd_commit();
        logic       taken, mis;
        logic [7:0] ckpt;
        taken = bus.upd_taken;
        mis   = bus.upd_mispred;
        ckpt  = bus.upd_ckpt;
        tick();
        bus.upd_valid   = 1'b0;
        bus.upd_taken   = 1'b0;
        bus.upd_mispred = 1'b0;
`ifdef BP_SPEC_HIST_EN
        if (mis) bhr_m = {ckpt[6:0], taken};
`else
        bhr_m = {bhr_m[6:0], taken};
`endif
        if (mis && perf_m != 32'hFFFF_FFFF) perf_m = perf_m + 32'd1;
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                          input logic mis, input logic [7:0] idx, input logic [7:0] ckpt);
        upd_drive(pc, tgt, taken, mis, idx, ckpt);
        upd_commit();
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk(name, n, 256);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        failures = 0;
        bhr_m    = 8'h00;
        perf_m   = 32'd0;
        reset    = 1'b0;
        bus.pred_valid  = 1'b0;
        bus.pred_pc     = '0;
        bus.upd_valid   = 1'b0;
        bus.upd_pc      = '0;
        bus.upd_target  = '0;
        bus.upd_taken   = 1'b0;
        bus.upd_mispred = 1'b0;
        bus.upd_pht_idx = '0;
        bus.upd_ckpt    = '0;

        vecs[0] = '{pc: 32'h0000_0000, taken: 1'b1, hit: 1'b0, idx: 8'h00};
        vecs[1] = '{pc: 32'h0000_0004, taken: 1'b1, hit: 1'b0, idx: 8'h01};
        vecs[2] = '{pc: 32'h0000_03FC, taken: 1'b1, hit: 1'b0, idx: 8'hFF};
        vecs[3] = '{pc: 32'h0000_1234, taken: 1'b1, hit: 1'b0, idx: 8'h8D};
        vecs[4] = '{pc: 32'hFFFF_FFFC, taken: 1'b1, hit: 1'b0, idx: 8'hFF};
        vecs[5] = '{pc: 32'h0000_1040, taken: 1'b1, hit: 1'b0, idx: 8'h10};

        // Reset state and init sweep length.
        repeat (3) tick();
        chk("rst_ready", bus.ready, 0);
        chk("rst_perf", bus.perf_mispred_cnt, 0);
        chk("rst_bhr", bus.pred_ckpt, 0);
        reset = 1'b1;
        bus.pred_pc = 32'h0000_1040;
        #1;
        chk("init_taken", bus.pred_taken, 0);
        chk("init_hit", bus.pred_btb_hit, 0);
        wait_ready("sweep_len");

        // Post-sweep lookups across a spread of PCs.
        for (int i = 0; i < 6; i++) begin
            bus.pred_pc = vecs[i].pc;
            #1;
            chk($sformatf("vec%0d_taken", i), bus.pred_taken, vecs[i].taken);
            chk($sformatf("vec%0d_hit", i), bus.pred_btb_hit, vecs[i].hit);
            chk($sformatf("vec%0d_idx", i), bus.pred_pht_idx, vecs[i].idx);
            chk($sformatf("vec%0d_ckpt", i), bus.pred_ckpt, 8'h00);
        end

        // Counter at idx 5: old value visible in the update cycle, saturate at 0.
        bus.pred_pc = pc_for_idx(8'h05);
        upd_drive(32'h0000_0504, 32'h0, 1'b0, 1'b0, 8'h05, bhr_m);
        #1;
        chk("pht_same_cycle_old", bus.pred_taken, 1);
        upd_commit();
        do_upd(32'h0000_0504, 32'h0, 1'b0, 1'b0, 8'h05, bhr_m);
        do_upd(32'h0000_0504, 32'h0, 1'b0, 1'b0, 8'h05, bhr_m);
        bus.pred_pc = pc_for_idx(8'h05);
        #1;
        chk("pht_sat_low", bus.pred_taken, 0);
        chk("pht_idx5", bus.pred_pht_idx, 8'h05);
        do_upd(32'h0000_0504, 32'h0, 1'b1, 1'b0, 8'h05, bhr_m);
        do_upd(32'h0000_0504, 32'h0, 1'b1, 1'b0, 8'h05, bhr_m);
        bus.pred_pc = pc_for_idx(8'h05);
        #1;
        chk("pht_recover", bus.pred_taken, 1);
        chk("bhr_after_upd", bus.pred_ckpt, bhr_m);

        // Counter at idx 7: saturate at 3, then two decrements reach 1.
        for (int i = 0; i < 3; i++) do_upd(32'h0000_0504, 32'h0, 1'b1, 1'b0, 8'h07, bhr_m);
        for (int i = 0; i < 2; i++) do_upd(32'h0000_0508, 32'h0, 1'b0, 1'b0, 8'h07, bhr_m);
        bus.pred_pc = pc_for_idx(8'h07);
        #1;
        chk("pht_sat_high", bus.pred_taken, 0);

        // BTB install, alias miss, not-taken keeps entry, replacement.
        bus.pred_pc = 32'h0000_1040;
        upd_drive(32'h0000_1040, 32'h0000_2000, 1'b1, 1'b0, idx_of(32'h0000_1040), bhr_m);
        #1;
        chk("btb_same_cycle", bus.pred_btb_hit, 0);
        upd_commit();
        chk("btb_hit", bus.pred_btb_hit, 1);
        chk("btb_target", bus.pred_target, 32'h0000_2000);
        bus.pred_pc = 32'h0000_2040;
        #1;
        chk("btb_alias_miss", bus.pred_btb_hit, 0);
        do_upd(32'h0000_1040, 32'hDEAD_0000, 1'b0, 1'b0, idx_of(32'h0000_1040), bhr_m);
        bus.pred_pc = 32'h0000_1040;
        #1;
        chk("btb_nt_keep_hit", bus.pred_btb_hit, 1);
        chk("btb_nt_keep_tgt", bus.pred_target, 32'h0000_2000);
        do_upd(32'h0000_2040, 32'h0000_3000, 1'b1, 1'b0, idx_of(32'h0000_2040), bhr_m);
        bus.pred_pc = 32'h0000_2040;
        #1;
        chk("btb_repl_hit", bus.pred_btb_hit, 1);
        chk("btb_repl_tgt", bus.pred_target, 32'h0000_3000);
        bus.pred_pc = 32'h0000_1040;
        #1;
        chk("btb_evicted", bus.pred_btb_hit, 0);

        // History behaviour for the configured mode.
`ifdef BP_SPEC_HIST_EN
        do_upd(32'h0000_0600, 32'h0, 1'b0, 1'b1, idx_of(32'h0000_0600), 8'h00);
        chk("spec_bhr_zero", bus.pred_ckpt, 8'h00);
        for (int i = 0; i < 2; i++) begin
            bus.pred_pc    = pc_for_idx(8'hC3);
            bus.pred_valid = 1'b1;
            #1;
            chk("spec_pred_taken", bus.pred_taken, 1);
            tick();
            bhr_m = {bhr_m[6:0], 1'b1};
        end
        bus.pred_valid = 1'b0;
        chk("spec_bhr_shift", bus.pred_ckpt, 8'h03);
        bus.pred_pc    = pc_for_idx(8'hC3);
        bus.pred_valid = 1'b1;
        do_upd(32'h0000_0600, 32'h0, 1'b0, 1'b1, idx_of(32'h0000_0600), 8'h00);
        bus.pred_valid = 1'b0;
        chk("spec_recover", bus.pred_ckpt, 8'h00);
`else
        bus.pred_valid = 1'b1;
        bus.pred_pc    = 32'h0000_1234;
        tick();
        tick();
        bus.pred_valid = 1'b0;
        chk("nospec_lookup_hold", bus.pred_ckpt, bhr_m);
        bus.pred_valid = 1'b1;
        do_upd(32'h0000_0600, 32'h0, 1'b0, 1'b1, idx_of(32'h0000_0600), 8'h55);
        bus.pred_valid = 1'b0;
        chk("nospec_upd_shift", bus.pred_ckpt, bhr_m);
`endif
        chk("perf_count", bus.perf_mispred_cnt, perf_m);

        // Mispredict counter saturation.
        force dut.perf_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.perf_cnt;
        perf_m = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            do_upd(32'h0000_0700, 32'h0, 1'b0, 1'b1, idx_of(32'h0000_0700), bhr_m);
            chk($sformatf("perf_sat%0d", i), bus.perf_mispred_cnt, perf_m);
        end

        // Asynchronous reset in RUN, then again in the middle of the sweep.
        bus.pred_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("async_rst_ready", bus.ready, 0);
        chk("async_rst_perf", bus.perf_mispred_cnt, 0);
        chk("async_rst_bhr", bus.pred_ckpt, 0);
        bhr_m  = 8'h00;
        perf_m = 32'd0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i == 4) upd_drive(32'h0000_0900, 32'h0000_4000, 1'b1, 1'b1, 8'h05, 8'hAA);
            tick();
            bus.upd_valid   = 1'b0;
            bus.upd_taken   = 1'b0;
            bus.upd_mispred = 1'b0;
        end
        chk("midsweep_ready", bus.ready, 0);
        chk("init_upd_no_bhr", bus.pred_ckpt, 0);
        reset = 1'b0;
        #1;
        chk("midsweep_rst_ready", bus.ready, 0);
        tick();
        reset = 1'b1;
        wait_ready("resweep_len");
        chk("init_upd_no_perf", bus.perf_mispred_cnt, 0);
        chk("resweep_bhr", bus.pred_ckpt, 0);
        bus.pred_pc = pc_for_idx(8'h05);
        #1;
        chk("pht_reinit", bus.pred_taken, 1);
        bus.pred_pc = 32'h0000_2040;
        #1;
        chk("btb_reinit", bus.pred_btb_hit, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_gshare_param.md
BP_GSHARE_PARAM -- requirements
Module: bp_gshare_param

Interface
REQ-001 Parameter DBITS, default 32, PC/target width.
REQ-002 Parameter HIST_BITS, default 8, global history length; PHT has 2^HIST_BITS entries.
REQ-003 Parameter BTB_IDX_BITS, default 4, BTB has 2^BTB_IDX_BITS entries; HIST_BITS >= BTB_IDX_BITS SHALL hold.
REQ-004 Parameter CTR_INIT, default 2, PHT counter value written by init sweep.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 pred_valid  in  1  fetch lookup this cycle.
REQ-009 pred_pc  in  DBITS  fetch PC.
REQ-010 pred_taken  out  1  predicted direction.
REQ-011 pred_btb_hit  out  1  BTB tag hit.
REQ-012 pred_target  out  DBITS  BTB target.
REQ-013 pred_pht_idx  out  HIST_BITS  PHT index used; carried with branch.
REQ-014 pred_ckpt  out  HIST_BITS  BHR value used; carried with branch.
REQ-015 upd_valid  in  1  resolved branch this cycle.
REQ-016 upd_pc / upd_target  in  DBITS  resolved branch PC / actual target.
REQ-017 upd_taken / upd_mispred  in  1  actual direction / misprediction flag.
REQ-018 upd_pht_idx / upd_ckpt  in  HIST_BITS  values returned from REQ-013/014.
REQ-019 ready  out  1  tables initialised.
REQ-020 perf_mispred_cnt  out  32  saturating mispredict count.

Function
REQ-021 Lookup combinational, same cycle: pht_idx = BHR ^ pred_pc[HIST_BITS+1:2]; pred_taken = PHT[pht_idx][1].
REQ-022 BTB index pred_pc[BTB_IDX_BITS+1:2]; tag pred_pc[DBITS-1:BTB_IDX_BITS+2]; hit = valid & tag equal.
REQ-023 FSM INIT->RUN: INIT writes CTR_INIT to PHT[i] and clears BTB valid[i mod 2^BTB_IDX_BITS], i=0..2^HIST_BITS-1, one per cycle; enters RUN after last index; ready=1 only in RUN.
REQ-024 In INIT: pred_taken=0, pred_btb_hit=0, updates ignored, BHR held.
REQ-025 Update (RUN, upd_valid): PHT[upd_pht_idx] 2-bit saturating +1 if taken, -1 if not; 3 and 0 saturate.
REQ-026 BTB written only when upd_valid & upd_taken: tag, upd_target, valid=1; not-taken never invalidates.
REQ-027 Writes occur at clock edge; same-cycle lookup of the updated entry sees the old value.
REQ-028 perf_mispred_cnt increments on upd_valid & upd_mispred in RUN; holds at 0xFFFFFFFF.
REQ-029 Non-speculative history (macro absent): on upd_valid, BHR <= {BHR[HIST_BITS-2:0], upd_taken}.

Reset
REQ-030 reset low: FSM=INIT, i=0, BHR=0, ready=0, perf_mispred_cnt=0, immediately, without clock.
REQ-031 Reset asserted mid-sweep or mid-run restarts the full sweep from index 0 after release.
REQ-032 Table contents are not reset directly; only the sweep initialises them.

Configuration
REQ-033 Macro BP_SPEC_HIST_EN: when defined, on pred_valid & ready, BHR <= {BHR[HIST_BITS-2:0], pred_taken}.
REQ-034 With BP_SPEC_HIST_EN, on upd_valid & upd_mispred, BHR <= {upd_ckpt[HIST_BITS-2:0], upd_taken}; recovery wins over a simultaneous lookup shift; correctly predicted updates leave BHR unchanged.
REQ-035 Without BP_SPEC_HIST_EN, REQ-029 applies and pred_valid does not affect BHR.

Structure
REQ-036 Package bp_pkg holds counter encodings (SNT=0, WNT=1, WT=2, ST=3), FSM state enum, BTB entry field widths derived from parameters.
REQ-037 Sub-module bp_btb holds BTB valid/tag/target arrays, lookup compare and write port.

Verification
REQ-038 Reset release, HIST_BITS=8 -> ready=0 for 256 cycles, ready=1 on cycle 257; pred_taken=1 (CTR_INIT=2) for any PC.
REQ-039 Three not-taken updates to idx 0x05 -> counter 2->1->0->0; lookup hitting idx 0x05 gives pred_taken=0.
REQ-040 Taken update pc=0x1040, target=0x2000 -> next-cycle lookup 0x1040 gives btb_hit=1, target=0x2000; lookup 0x2040 (same index, other tag) gives btb_hit=0.
REQ-041 BP_SPEC_HIST_EN, BHR=0x00, two lookups predicting 1 -> BHR=0x03; mispredict upd_ckpt=0x00, upd_taken=0 same cycle as a lookup -> BHR=0x00.
REQ-042 Reset low at sweep index 100 -> ready stays 0, sweep restarts at 0, ready after 256 further cycles.
REQ-043 Force counter to 0xFFFFFFFE, two mispredict updates -> 0xFFFFFFFF, held.
